// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master/target pair: FSM state encoding and
// the default target address both sides agree on.
package i2c_pkg;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h73;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings the asynchronous SCL/SDA lines into sys_clk and flags SCL edges
// plus START/STOP conditions as single-cycle pulses.
module i2c_line_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;

  // NOTE: the synchronizers reset to 1 (idle bus level) so leaving reset
  // never fakes a START or an SCL edge on an idle bus.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  // SCL must be high on both sides of the SDA transition to count as START/STOP.
  assign scl_rise  = scl_sync[1] & ~scl_d;
  assign scl_fall  = ~scl_sync[1] & scl_d;
  assign start_det = scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
  assign stop_det  = scl_sync[1] & scl_d & ~sda_d & sda_sync[1];
  assign sda_s     = sda_sync[1];

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target: address match, register-pointer byte, then burst write into or
// burst read from an external register bank with pointer auto-increment.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int         REG_AW     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [REG_AW-1:0] reg_addr,
  input  logic [7:0]        reg_rdata,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              busy
);

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_s;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       rw;
  logic       ack_half;
  logic [7:0] rx_byte;

  i2c_line_sync u_line_sync (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  // Seven stored bits plus the bit arriving on this rise form the full byte.
  assign rx_byte = {shift, sda_s};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rw        <= 1'b0;
      ack_half  <= 1'b0;
      sda_oe    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_wdata <= '0;
      reg_addr  <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: strobe defaults low every cycle; only the WDATA branch raises it.
      reg_wr <= 1'b0;
      if (reg_wr) reg_addr <= reg_addr + REG_AW'(1);

      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_half <= 1'b0;
                if (state == ST_ADDR) begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    rw    <= rx_byte[0];
                    state <= ST_ADDR_ACK;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end else if (state == ST_PTR) begin
                  reg_addr <= rx_byte[REG_AW-1:0];
                  state    <= ST_PTR_ACK;
                end else begin
                  reg_wr    <= 1'b1;
                  reg_wdata <= rx_byte;
                  state     <= ST_WDATA_ACK;
                end
              end
            end
          end

          // First fall pulls SDA low for the ACK slot, second fall ends it.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_half) begin
                sda_oe   <= 1'b1;
                ack_half <= 1'b1;
              end else begin
                bit_cnt <= '0;
                if (state == ST_ADDR_ACK && rw) begin
                  shift  <= reg_rdata[6:0];
                  sda_oe <= ~reg_rdata[7];
                  busy   <= 1'b1;
                  state  <= ST_RDATA;
                end else begin
                  sda_oe <= 1'b0;
                  if (state == ST_ADDR_ACK) begin
                    busy  <= 1'b1;
                    state <= ST_PTR;
                  end else begin
                    state <= ST_WDATA;
                  end
                end
              end
            end
          end

          ST_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe   <= 1'b0;
                bit_cnt  <= '0;
                ack_half <= 1'b0;
                state    <= ST_RDATA_ACK;
              end else begin
                sda_oe  <= ~shift[6];
                shift   <= {shift[5:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          // The byte just sent is consumed either way; NACK ends the burst.
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              reg_addr <= reg_addr + REG_AW'(1);
              if (sda_s) state <= ST_IGNORE;
              else ack_half <= 1'b1;
            end else if (scl_fall && ack_half) begin
              shift   <= reg_rdata[6:0];
              sda_oe  <= ~reg_rdata[7];
              bit_cnt <= '0;
              state   <= ST_RDATA;
            end
          end

          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule
